// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared types, default parameters and grant decode for the tri-bus arbiter.
package tri_bus_pkg;
  localparam int NREQ_DEF = 4;
  localparam int MAX_HOLD_DEF = 4;
  localparam int TURN_CYC_DEF = 2;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction
endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or above ptr with wrap.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int OW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic            valid,
  output logic [OW-1:0]   idx
);
  logic [OW-1:0] j;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = OW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        valid = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner controller for a shared wired bus with bounded hold and float gap.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF,
  localparam int OW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] oe,
  output logic [OW-1:0]   owner,
  output logic            busy,
  output logic            preempt
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx, nxt;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic busy_q, busy_d, preempt_q, preempt_d, pick_valid, rel, lim;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  assign rel = !req[owner_q];
  assign lim = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
  assign nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    turn_d = turn_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        state_d = DRIVE;
        owner_d = pick_idx;
        hold_d = HW'(1);
      end
      DRIVE: if (rel || lim) begin
        state_d = TURN;
        turn_d = 4'd1;
        ptr_d = nxt;
        hold_d = '0;
        preempt_d = !rel;
      end else if (MAX_HOLD != 0) begin
        hold_d = hold_q + 1'b1;
      end
      TURN: if (turn_q == 4'(TURN_CYC)) begin
        state_d = pick_valid ? DRIVE : IDLE;
        owner_d = pick_valid ? pick_idx : owner_q;
        hold_d = HW'(1);
        turn_d = '0;
      end else begin
        turn_d = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == DRIVE) ? NREQ'(onehot(4'(owner_d))) : '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      turn_q <= '0;
      gnt_q <= '0;
      busy_q <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      preempt_q <= preempt_d;
    end
  end
  // oe and gnt share one flop: they are identical outside DRIVE (both zero) and equal inside it
  assign gnt = gnt_q;
  assign oe = gnt_q;
  assign owner = owner_q;
  assign busy = busy_q;
  assign preempt = preempt_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed scenarios plus random traffic checked against a behavioural model.
module tb_tri_bus_arbiter;
  localparam int N = 4;
  localparam int MH = 4;
  localparam int TC = 2;
  localparam int STARVE = 3 * (MH + TC);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt, oe;
  logic [1:0] owner;
  logic busy, preempt;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  tri_bus_arbiter #(.NREQ(N), .MAX_HOLD(MH), .TURN_CYC(TC)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .oe     (oe),
    .owner  (owner),
    .busy   (busy),
    .preempt(preempt)
  );
  typedef struct {
    int mode;
    int owner;
    int ptr;
    int len;
    int flt;
    bit pre;
  } mst_t;
  mst_t m;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[2'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction
  function automatic mst_t step(input mst_t s, input logic [3:0] r, input logic rs);
    mst_t n = s;
    int p;
    n.pre = 1'b0;
    if (rs) begin
      n.mode = 0; n.owner = 0; n.ptr = 0; n.len = 0; n.flt = 0;
      return n;
    end
    p = pick(r, s.ptr);
    if (s.mode == 1) begin
      if (!r[2'(s.owner)] || s.len == MH) begin
        n.mode = 2; n.flt = 1; n.ptr = (s.owner + 1) % N; n.pre = r[2'(s.owner)];
      end else n.len = s.len + 1;
    end else if ((s.mode == 0 || s.flt == TC) && p >= 0) begin
      n.mode = 1; n.owner = p; n.len = 1;
    end else if (s.mode == 2) begin
      if (s.flt == TC) n.mode = 0;
      else n.flt = s.flt + 1;
    end
    return n;
  endfunction
  function automatic logic [3:0] exp_oe(input mst_t s);
    return s.mode == 1 ? 4'(1 << s.owner) : 4'h0;
  endfunction
  always @(posedge clk) begin
    m <= step(m, req, rst);
    if (rst) armed <= 1'b1;
  end
  logic [3:0] last_nz = '0;
  int zrun = 0;
  int wait_cnt[4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    if (armed) begin
      check("oe", oe, exp_oe(m));
      check("gnt", gnt, exp_oe(m));
      check("owner", owner, m.owner);
      check("busy", busy, m.mode != 0);
      check("preempt", preempt, m.pre);
      check("oe_onehot0", $onehot0(oe), 1);
      if (oe != 0 && last_nz != 0 && oe != last_nz) check("turn_gap", zrun >= TC, 1);
      for (int i = 0; i < N; i++) begin
        check("starve", wait_cnt[i] <= STARVE, 1);
        if (rst || !req[2'(i)] || oe[2'(i)]) wait_cnt[i] <= 0;
        else if (m.owner != i) wait_cnt[i] <= wait_cnt[i] + 1;
      end
      if (rst) begin
        last_nz <= '0;
        zrun <= 0;
      end else if (oe != 0) begin
        last_nz <= oe;
        zrun <= 0;
      end else zrun <= zrun + 1;
    end
  end
  task automatic tick(input logic [3:0] r, input logic rs);
    @(posedge clk);
    #2;
    req = r;
    rst = rs;
    @(negedge clk);
  endtask
  initial begin
    logic [3:0] r1[6] = '{1, 1, 0, 0, 0, 0};
    logic [3:0] e1_oe[6] = '{1, 1, 1, 0, 0, 0};
    logic e1_busy[6] = '{1, 1, 1, 1, 1, 0};
    logic [3:0] e2_oe[13] = '{1, 1, 1, 1, 0, 0, 2, 2, 2, 2, 0, 0, 1};
    logic [1:0] e2_own[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] r;
    tick(4'h0, 1'b1);
    tick(4'h1, 1'b0);
    check("rst_oe", oe, 0);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_preempt", preempt, 0);
    for (int i = 0; i < 6; i++) begin
      tick(r1[i], 1'b0);
      check("single_oe", oe, e1_oe[i]);
      check("single_busy", busy, e1_busy[i]);
      check("single_preempt", preempt, 0);
    end
    tick(4'h0, 1'b1);
    tick(4'h3, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick(4'h3, 1'b0);
      check("preempt_oe", oe, e2_oe[i]);
      check("preempt_owner", owner, e2_own[i]);
      check("preempt_pulse", preempt, (i == 4 || i == 10) ? 1 : 0);
    end
    tick(4'h0, 1'b1);
    tick(4'h4, 1'b0);
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    tick(4'h9, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick(4'h9, 1'b0);
      if (i == 1) begin
        check("wrap_first_owner", owner, 3);
        check("wrap_first_oe", oe, 8);
      end
      if (i == 7) begin
        check("wrap_second_owner", owner, 0);
        check("wrap_second_oe", oe, 1);
      end
    end
    tick(4'h0, 1'b1);
    tick(4'h1, 1'b0);
    tick(4'h1, 1'b0);
    tick(4'h1, 1'b0);
    tick(4'h1, 1'b0);
    tick(4'h0, 1'b0);
    check("simul_4th_oe", oe, 1);
    tick(4'h0, 1'b0);
    check("simul_turn_oe", oe, 0);
    check("simul_turn_busy", busy, 1);
    check("simul_no_preempt", preempt, 0);
    tick(4'h0, 1'b1);
    tick(4'h4, 1'b0);
    tick(4'h4, 1'b0);
    check("rstdrv_first_oe", oe, 4);
    tick(4'h4, 1'b1);
    check("rstdrv_second_oe", oe, 4);
    tick(4'h4, 1'b0);
    check("rstdrv_oe", oe, 0);
    check("rstdrv_gnt", gnt, 0);
    check("rstdrv_owner", owner, 0);
    tick(4'h4, 1'b0);
    check("rstdrv_regrant_oe", oe, 4);
    r = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[2'(b)] = !r[2'(b)];
      tick(r, $urandom_range(0, 399) == 0);
    end
    tick(4'h0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
